// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the single-bus datapath.
// Fetches an instruction (T0..T2), latches its opcode, then steps through the
// execute sequence for R-ALU, I-ALU, ld, st, halt or illegal opcodes.
// Memory steps wait on Mem_ready with a bounded timeout that raises Bus_error.
// Ports:
//   Clock, Clear (sync active-high), IR, Mem_ready, Stop  - inputs
//   PCout..Rout strobes, ALU_op                            - datapath controls
//   Run, Bus_error (sticky), Illegal (pulse), State        - status / debug
module control_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OPCODE_W   = 5,
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  Mem_ready,
  input  logic                  Stop,
  output logic                  PCout,
  output logic                  Zlowout,
  output logic                  MDRout,
  output logic                  BAout,
  output logic                  Cout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  IncPC,
  output logic                  Read,
  output logic                  Write,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic [ALU_OP_W-1:0]   ALU_op,
  output logic                  Run,
  output logic                  Bus_error,
  output logic                  Illegal,
  output logic [3:0]            State
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(27);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd15
  } state_t;

  state_t              state, state_next, boundary;
  logic [OPCODE_W-1:0] opcode;
  logic [CNT_W-1:0]    wait_cnt, cnt_next;
  logic                stop_pend;
  logic                wait_step, timeout;
  logic                is_ralu, is_ialu, is_ld, is_st, is_halt, is_illegal;
  logic [1:0]          alu_sel;

  // Operand bits of IR are decoded by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^IR[DATA_WIDTH-OPCODE_W-1:0];

  // Instruction class decode from the latched opcode.
  assign is_ralu    = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign is_ialu    = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_ld      = (opcode == OP_LD);
  assign is_st      = (opcode == OP_ST);
  assign is_halt    = (opcode == OP_HALT);
  assign is_illegal = !(is_ralu || is_ialu || is_ld || is_st || is_halt);

  // ALU function: 0=ADD, 1=SUB, 2=AND, 3=OR.
  always_comb begin
    alu_sel = 2'd0;
    if (opcode == OP_SUB) alu_sel = 2'd1;
    if (opcode == OP_AND || opcode == OP_ANDI) alu_sel = 2'd2;
    if (opcode == OP_OR  || opcode == OP_ORI)  alu_sel = 2'd3;
  end

  // State register, wait counter, sticky error, opcode latch, pending stop.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state     <= S_RESET;
      wait_cnt  <= '0;
      Bus_error <= 1'b0;
      opcode    <= '0;
      stop_pend <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
      if (timeout) Bus_error <= 1'b1;
      if (state == S_T2) opcode <= IR[DATA_WIDTH-1 -: OPCODE_W];
      // A stop request is remembered until the next instruction boundary.
      stop_pend <= (state_next == S_HALT) ? 1'b0 : (stop_pend | Stop);
    end
  end

  // Next-state logic including memory wait steps.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    timeout    = 1'b0;
    wait_step  = 1'b0;
    boundary   = (Stop || stop_pend) ? S_HALT : S_T0;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1: begin
        wait_step  = 1'b1;
        state_next = S_T2;
      end
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (is_halt)         state_next = S_HALT;
        else if (is_illegal) state_next = boundary;
        else                 state_next = S_T4;
      end
      S_T4:    state_next = S_T5;
      S_T5:    state_next = (is_ralu || is_ialu) ? boundary : S_T6;
      S_T6: begin
        wait_step  = is_ld;
        state_next = S_T7;
      end
      S_T7: begin
        wait_step  = is_st;
        state_next = boundary;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
    // Hold while memory is busy; the TIMEOUT-th busy cycle aborts to HALT.
    if (wait_step && !Mem_ready) begin
      if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
        state_next = S_HALT;
        timeout    = 1'b1;
      end else begin
        state_next = state;
        cnt_next   = wait_cnt + CNT_W'(1);
      end
    end
  end

  // Moore output decode from state and latched opcode.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    ALU_op  = '0;
    Illegal = 1'b0;
    Run     = (state != S_RESET) && (state != S_HALT);
    State   = state;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_ralu || is_ialu) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (is_ld || is_st)     begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        Illegal = is_illegal;
      end
      S_T4: begin
        Zin = 1'b1;
        if (is_ralu) begin Grc = 1'b1; Rout = 1'b1; end
        else         Cout = 1'b1;
        if (is_ralu || is_ialu) ALU_op = ALU_OP_W'(alu_sel);
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ralu || is_ialu) begin Gra = 1'b1; Rin = 1'b1; end
        else                    MARin = 1'b1;
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_ld) Read = 1'b1;
        else begin Gra = 1'b1; Rout = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else       Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that replaces bench-driven T0..T5 control with an on-chip Moore FSM. It fetches instructions, decodes the opcode from the IR, and drives the existing datapath strobes for R-type ALU, I-type ALU, load, store and halt. Memory accesses use a ready handshake with a bounded timeout. The block sits between the IR and the datapath control inputs, one instance per datapath.

## Interface
- DATA_WIDTH, 32: IR width; opcode = IR[DATA_WIDTH-1 -: OPCODE_W]
- OPCODE_W, 5: opcode field width
- ALU_OP_W, 4: width of ALU_op
- TIMEOUT, 15: maximum consecutive Mem_ready-low cycles in a wait step (>=1)

- Clock  in  1  system clock, rising edge
- Clear  in  1  synchronous, active-high reset
- IR  in  DATA_WIDTH  instruction register contents
- Mem_ready  in  1  memory completes the current Read/Write this cycle
- Stop  in  1  request halt at the next instruction boundary
- PCout, Zlowout, MDRout, BAout, Cout  out  1 each  bus drive enables
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  PC increment, memory strobes
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select/enable
- ALU_op  out  ALU_OP_W  0=ADD, 1=SUB, 2=AND, 3=OR
- Run  out  1  high in every state except RESET and HALT
- Bus_error  out  1  sticky; memory timeout occurred
- Illegal  out  1  one-cycle pulse on an undefined opcode
- State  out  4  debug: RESET=0, T0..T7=1..8, HALT=15

## Operation
- Opcodes: ld=00000, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01011, andi=01100, ori=01101, halt=11011. All others are illegal.
- All strobes and ALU_op are a decode of the state register plus the latched opcode. Unlisted strobes are 0. ALU_op is 0 unless listed.
- Fetch, common to all instructions:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin (wait step).
  - T2: MDRout IRin.
- Opcode is latched at the end of T2 from the IR value written that cycle.
- R-ALU: T3 Grb Rout Yin; T4 Grc Rout Zin ALU_op=op; T5 Zlowout Gra Rin; then T0.
- I-ALU: T3 Grb Rout Yin; T4 Cout Zin ALU_op=op; T5 Zlowout Gra Rin; then T0.
- ld: T3 Grb BAout Yin; T4 Cout Zin ADD; T5 Zlowout MARin; T6 Read MDRin (wait); T7 MDRout Gra Rin; then T0.
- st: T3 Grb BAout Yin; T4 Cout Zin ADD; T5 Zlowout MARin; T6 Gra Rout MDRin; T7 Write (wait); then T0.
- halt: T3 goes to HALT with no strobes.
- Illegal opcode: T3 pulses Illegal, no strobes, then T0.
- Stop sampled at an instruction's final step: if 1, go to HALT instead of T0.
- Only Clear leaves HALT.

## Timing
- Clear=1 at an edge: state=RESET, wait counter=0, Bus_error=0, opcode latch=0. All outputs are 0 the following cycle.
- Clear overrides everything, including mid-instruction and wait steps.
- RESET goes to T0 on the first edge with Clear=0.
- Wait steps (T1; T6 for ld; T7 for st): the state advances only on an edge where Mem_ready=1.
  - Strobes are held steady while waiting.
  - The counter increments each Mem_ready-low cycle and resets on leaving the step.
  - If the counter reaches TIMEOUT with Mem_ready still 0: Bus_error<=1, go to HALT.
- Zero-wait latency, T0 to next T0: 6 cycles for R/I-ALU, 8 for ld/st, 4 for illegal. Each wait cycle adds 1.
- Mem_ready outside wait steps is ignored.

## Test plan
- Reset, then IR=0x590FFFFB (addi), Mem_ready=1:
  - Six cycles T0..T5 with the exact strobes above; T4 shows Cout Zin ALU_op=0.
  - Returns to T0; Run=1 throughout.
- IR opcode sub (00100), Mem_ready=1: T4 shows Grc Rout Zin ALU_op=1; T5 Zlowout Gra Rin.
- ld with Mem_ready low for 3 cycles in T6:
  - T6 is held 4 cycles with Read MDRin steady.
  - Instruction takes 11 cycles; Bus_error stays 0.
- st with Mem_ready stuck low in T7, TIMEOUT=15:
  - After 15 low cycles, Bus_error=1 and State=15.
  - Clear returns State=0 and Bus_error=0.
- Opcode 11111: Illegal is high for exactly one cycle in T3, no strobes, next state T0. Then halt opcode gives State=15 and Run=0.
- Stop=1 pulsed during T3 of addi: the instruction completes T5, then HALT. Clear asserted in T4 of a second run gives RESET next cycle with all outputs 0.
